// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-pipe instructions in
// dispatch order, retires them in order, and flags RAW/WAW collisions at dispatch.
module exu_oitf #(
  parameter int OITF_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int RFIDX_W    = 5,
  parameter int PC_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dis_ena,
  input  logic [RFIDX_W-1:0] dis_rdidx,
  input  logic               dis_rdwen,
  input  logic [PC_W-1:0]    dis_pc,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               ret_ena,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic               ret_rdwen,
  output logic [PC_W-1:0]    ret_pc,
  output logic               oitf_empty,
  output logic               oitf_full,
  output logic [PTR_W:0]     oitf_cnt,
  input  logic               disp_rs1en,
  input  logic               disp_rs2en,
  input  logic               disp_rdwen,
  input  logic [RFIDX_W-1:0] disp_rs1idx,
  input  logic [RFIDX_W-1:0] disp_rs2idx,
  input  logic [RFIDX_W-1:0] disp_rdidx,
  output logic               match_rs1,
  output logic               match_rs2,
  output logic               match_rd
);

  logic [PTR_W:0]      wptr_p0;
  logic [PTR_W:0]      rptr_p0;
  logic [OITF_DEPTH-1:0] vld_p0;
  logic [OITF_DEPTH-1:0] rdwen_p0;
  logic [RFIDX_W-1:0]  rdidx_p0 [OITF_DEPTH];
  logic [PC_W-1:0]     pc_p0    [OITF_DEPTH];

  logic alloc;
  logic retire;

  assign dis_ptr    = wptr_p0[PTR_W-1:0];
  assign ret_ptr    = rptr_p0[PTR_W-1:0];
  assign oitf_empty = (wptr_p0 == rptr_p0);
  assign oitf_full  = (wptr_p0[PTR_W-1:0] == rptr_p0[PTR_W-1:0]) &&
                      (wptr_p0[PTR_W] != rptr_p0[PTR_W]);
  assign oitf_cnt   = wptr_p0 - rptr_p0;

  // Legality is judged on pre-edge state, so at full a simultaneous allocate is dropped.
  assign alloc  = dis_ena && !oitf_full;
  assign retire = ret_ena && !oitf_empty;

  assign ret_rdidx = rdidx_p0[ret_ptr];
  assign ret_rdwen = rdwen_p0[ret_ptr];
  assign ret_pc    = pc_p0[ret_ptr];

  // ---- stage p0: entry storage and pointers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_p0  <= '0;
      rptr_p0  <= '0;
      vld_p0   <= '0;
      rdwen_p0 <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_p0[i] <= '0;
        pc_p0[i]    <= '0;
      end
    end else begin
      if (retire) begin
        vld_p0[ret_ptr] <= 1'b0;
        rptr_p0         <= rptr_p0 + 1'b1;
      end
      // Allocate and retire never target the same slot: that needs full or empty.
      if (alloc) begin
        vld_p0[dis_ptr]   <= 1'b1;
        rdwen_p0[dis_ptr] <= dis_rdwen;
        rdidx_p0[dis_ptr] <= dis_rdidx;
        pc_p0[dis_ptr]    <= dis_pc;
        wptr_p0           <= wptr_p0 + 1'b1;
      end
    end
  end

  // Hazard compare over registered entries only; x0 destinations never collide.
  always_comb begin
    logic hit1;
    logic hit2;
    logic hitd;
    logic live;
    hit1 = 1'b0;
    hit2 = 1'b0;
    hitd = 1'b0;
    live = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      live = vld_p0[i] && rdwen_p0[i] && (rdidx_p0[i] != '0);
      if (live && (rdidx_p0[i] == disp_rs1idx)) hit1 = 1'b1;
      if (live && (rdidx_p0[i] == disp_rs2idx)) hit2 = 1'b1;
      if (live && (rdidx_p0[i] == disp_rdidx))  hitd = 1'b1;
    end
    match_rs1 = disp_rs1en && hit1;
    match_rs2 = disp_rs2en && hit2;
    match_rd  = disp_rdwen && hitd;
  end

endmodule

// File: tb/tb_exu_oitf.sv
// Directed table-driven bench for exu_oitf: each row drives one cycle, checks the
// hazard flags before the edge and the FIFO state after it.
module tb_exu_oitf;
  localparam logic [31:0] PB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dis_ena, dis_rdwen, ret_ena;
  logic [4:0]  dis_rdidx;
  logic [31:0] dis_pc;
  logic [1:0]  dis_ptr, ret_ptr;
  logic [4:0]  ret_rdidx;
  logic        ret_rdwen;
  logic [31:0] ret_pc;
  logic        oitf_empty, oitf_full;
  logic [2:0]  oitf_cnt;
  logic        disp_rs1en, disp_rs2en, disp_rdwen;
  logic [4:0]  disp_rs1idx, disp_rs2idx, disp_rdidx;
  logic        match_rs1, match_rs2, match_rd;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exu_oitf #(.OITF_DEPTH(4), .PTR_W(2), .RFIDX_W(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .dis_ena(dis_ena), .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_pc(dis_pc),
    .dis_ptr(dis_ptr), .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
    .ret_rdwen(ret_rdwen), .ret_pc(ret_pc), .oitf_empty(oitf_empty), .oitf_full(oitf_full),
    .oitf_cnt(oitf_cnt), .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
    .disp_rdwen(disp_rdwen), .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx),
    .disp_rdidx(disp_rdidx), .match_rs1(match_rs1), .match_rs2(match_rs2), .match_rd(match_rd)
  );

  typedef struct {
    logic        rst, de, dwen, re;
    logic [4:0]  drd;
    logic [31:0] dpc;
    logic        s1en, s2en, dwe;
    logic [4:0]  s1, s2, dri;
    logic        em1, em2, emd;
    logic [2:0]  ecnt;
    logic [1:0]  edp, erp;
    logic [4:0]  err;
    logic [31:0] erpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, de, input logic [4:0] drd, input logic dwen, input logic [31:0] dpc,
    input logic re, input logic s1en, input logic [4:0] s1, input logic s2en,
    input logic [4:0] s2, input logic dwe, input logic [4:0] dri,
    input logic em1, em2, emd, input logic [2:0] ecnt, input logic [1:0] edp, erp,
    input logic [4:0] err, input logic [31:0] erpc);
    vec_t v;
    v.rst = r; v.de = de; v.drd = drd; v.dwen = dwen; v.dpc = dpc; v.re = re;
    v.s1en = s1en; v.s1 = s1; v.s2en = s2en; v.s2 = s2; v.dwe = dwe; v.dri = dri;
    v.em1 = em1; v.em2 = em2; v.emd = emd; v.ecnt = ecnt; v.edp = edp; v.erp = erp;
    v.err = err; v.erpc = erpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, de, input logic [4:0] drd, input logic dwen,
                       input logic [31:0] dpc, input logic re);
    rst = r; dis_ena = de; dis_rdidx = drd; dis_rdwen = dwen; dis_pc = dpc; ret_ena = re;
  endtask

  task automatic check_state(input string tag, input logic [2:0] ecnt, input logic [1:0] edp,
                             input logic [1:0] erp);
    chk({tag, ".cnt"},   oitf_cnt,   ecnt);
    chk({tag, ".empty"}, oitf_empty, (ecnt == 3'd0));
    chk({tag, ".full"},  oitf_full,  (ecnt == 3'd4));
    chk({tag, ".dis_ptr"}, dis_ptr,  edp);
    chk({tag, ".ret_ptr"}, ret_ptr,  erp);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
    disp_rs1idx = 0; disp_rs2idx = 0; disp_rdidx = 0;

    //           rst de drd dwen dpc          re  s1en s1 s2en s2 dwe dri  m1 m2 md cnt dp rp rrd  rpc
    tbl.push_back(mk(1, 0, 0, 0, 0,        0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0,  1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, PB,       0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 1, PB));
    tbl.push_back(mk(0, 1, 2, 1, PB+4,     0,  1, 1, 1, 2, 0, 0,   1, 0, 0, 2, 2, 0, 1, PB));
    tbl.push_back(mk(0, 1, 3, 1, PB+8,     0,  0, 0, 1, 2, 0, 0,   0, 1, 0, 3, 3, 0, 1, PB));
    tbl.push_back(mk(0, 1, 4, 1, PB+12,    0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 0, 0, 1, PB));
    tbl.push_back(mk(0, 1, 9, 1, 32'hDEAD, 0,  0, 0, 0, 0, 1, 4,   0, 0, 1, 4, 0, 0, 1, PB));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  1, 1, 0, 0, 0, 0,   1, 0, 0, 3, 0, 1, 2, PB+4));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  1, 1, 0, 0, 0, 0,   0, 0, 0, 2, 0, 2, 3, PB+8));
    tbl.push_back(mk(0, 1, 5, 1, PB+16,    0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 2, 3, PB+8));
    tbl.push_back(mk(0, 1, 6, 1, PB+20,    0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 2, 2, 3, PB+8));
    tbl.push_back(mk(0, 1, 10, 1, PB+40,   1,  0, 0, 0, 0, 1, 10,  0, 0, 0, 3, 2, 3, 4, PB+12));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 2, 0, 5, PB+16));
    tbl.push_back(mk(0, 1, 7, 1, PB+24,    1,  1, 10, 1, 5, 0, 0,  0, 1, 0, 2, 3, 1, 6, PB+20));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0,  1, 7, 1, 5, 1, 7,   1, 0, 1, 2, 3, 1, 6, PB+20));
    tbl.push_back(mk(0, 1, 0, 1, PB+28,    0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 1, 6, PB+20));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0,  1, 0, 0, 7, 0, 0,   0, 0, 0, 3, 0, 1, 6, PB+20));
    tbl.push_back(mk(0, 1, 8, 0, PB+32,    0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 1, 1, 6, PB+20));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0,  1, 8, 1, 6, 1, 8,   0, 1, 0, 4, 1, 1, 6, PB+20));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 2, 7, PB+24));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1, 3, 0, PB+28));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 8, PB+32));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 6, PB+20));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1,  0, 0, 1, 6, 0, 0,   0, 0, 0, 0, 1, 1, 6, PB+20));
    tbl.push_back(mk(0, 1, 11, 1, PB+48,   0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 1, 11, PB+48));
    tbl.push_back(mk(0, 1, 12, 1, PB+52,   0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 3, 1, 11, PB+48));
    tbl.push_back(mk(0, 1, 13, 1, PB+56,   0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 1, 11, PB+48));
    tbl.push_back(mk(1, 1, 14, 1, PB+60,   1,  1, 12, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0,  1, 12, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].de, tbl[i].drd, tbl[i].dwen, tbl[i].dpc, tbl[i].re);
      disp_rs1en = tbl[i].s1en; disp_rs1idx = tbl[i].s1;
      disp_rs2en = tbl[i].s2en; disp_rs2idx = tbl[i].s2;
      disp_rdwen = tbl[i].dwe;  disp_rdidx  = tbl[i].dri;
      #1;
      if (i > 0) begin
        chk({tag, ".match_rs1"}, match_rs1, tbl[i].em1);
        chk({tag, ".match_rs2"}, match_rs2, tbl[i].em2);
        chk({tag, ".match_rd"},  match_rd,  tbl[i].emd);
        if (tbl[i].de && !tbl[i].rst && oitf_full && !tbl[i].re)
          $display("[TB] note v%0d: protocol error, dis_ena while full (expected to be dropped)", i);
      end
      @(posedge clk);
      #1;
      check_state(tag, tbl[i].ecnt, tbl[i].edp, tbl[i].erp);
      chk({tag, ".ret_rdidx"}, ret_rdidx, tbl[i].err);
      chk({tag, ".ret_pc"},    ret_pc,    tbl[i].erpc);
      if (tbl[i].rst) begin
        chk({tag, ".ret_rdwen"}, ret_rdwen, 1'b0);
        chk({tag, ".rst_match_rs1"}, match_rs1, 1'b0);
      end
    end

    // Single-entry ping-pong across the pointer wrap: each entry must read back intact.
    disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc_k;
      logic [4:0]  rd_k;
      logic [1:0]  idx_k, nxt_k;
      pc_k  = PB + 32'h100 + 32'(4 * k);
      rd_k  = 5'(k + 1);
      idx_k = 2'(k % 4);
      nxt_k = 2'((k + 1) % 4);
      @(negedge clk);
      drive(1'b0, 1'b1, rd_k, k[0], pc_k, 1'b0);
      @(posedge clk);
      #1;
      check_state($sformatf("pp%0d.alloc", k), 3'd1, nxt_k, idx_k);
      chk($sformatf("pp%0d.ret_pc", k),    ret_pc,    pc_k);
      chk($sformatf("pp%0d.ret_rdidx", k), ret_rdidx, rd_k);
      chk($sformatf("pp%0d.ret_rdwen", k), ret_rdwen, k[0]);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
      @(posedge clk);
      #1;
      check_state($sformatf("pp%0d.retire", k), 3'd0, nxt_k, nxt_k);
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
